// File: rtl/motor_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module   : motor_pwm_driver
// Purpose  : Turns the signed PD command from the balance controller into a
//            fixed-period PWM waveform and the two direction pins of one
//            H-bridge channel. Commands take effect only at period boundaries,
//            and a direction reversal always inserts one full off period.
// Ports    : clk            system clock
//            rst            synchronous active-high reset
//            i_enable       level; 0 forces the bridge off on the next edge
//            i_pwm_cmd      signed duty command (clocks)
//            i_cmd_valid    one-cycle strobe capturing i_pwm_cmd
//            o_pwm_out      PWM to the bridge enable pin
//            o_ain1         forward direction pin
//            o_ain2         reverse direction pin
//            o_period_tick  high on the last clock of every period
//            o_saturated    active duty was clipped to MAX_DUTY
// Revision : 1.0 - initial release
// ============================================================================
module motor_pwm_driver #(
  parameter int PERIOD   = 1000,
  parameter int MAX_DUTY = 950,
  parameter int DEADBAND = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  input  logic [15:0] i_pwm_cmd,
  input  logic        i_cmd_valid,
  output logic        o_pwm_out,
  output logic        o_ain1,
  output logic        o_ain2,
  output logic        o_period_tick,
  output logic        o_saturated
);

  localparam logic [15:0] c_last_cnt  = 16'(PERIOD - 1);
  localparam logic [15:0] c_max_duty  = 16'(MAX_DUTY);
  localparam logic [16:0] c_max_mag   = 17'(MAX_DUTY);
  localparam logic [16:0] c_dead_mag  = 17'(DEADBAND);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_REVERSE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DIR_ZERO = 2'd0,
    DIR_POS  = 2'd1,
    DIR_NEG  = 2'd2
  } dir_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_next;
  logic [15:0] r_pending;
  logic [15:0] w_cmd_sel;
  logic [15:0] r_duty;
  logic [15:0] w_duty_next;
  dir_t        r_dir;
  dir_t        w_dir_next;
  logic        r_sat;
  logic        w_sat_next;
  logic        w_boundary;

  // Decoded form of the command that would be loaded this cycle
  logic [16:0] w_mag;
  logic [15:0] w_cv_duty;
  dir_t        w_cv_dir;
  logic        w_cv_sat;
  logic        w_reversal;

  logic        r_pwm;
  logic        r_ain1;
  logic        r_ain2;
  logic        r_tick;

  assign w_boundary = (r_cnt == c_last_cnt);

  // A strobe on the boundary cycle must win over the held value, so the
  // load path looks through the pending register.
  assign w_cmd_sel = i_cmd_valid ? i_pwm_cmd : r_pending;

  // 17-bit magnitude so that -32768 maps to +32768 without overflow.
  assign w_mag = w_cmd_sel[15] ? (17'd0 - {1'b1, w_cmd_sel}) : {1'b0, w_cmd_sel};

  always_comb begin
    w_cv_duty = 16'd0;
    w_cv_dir  = DIR_ZERO;
    w_cv_sat  = 1'b0;
    if ((w_mag >= c_dead_mag) && (w_mag != 17'd0)) begin
      w_cv_dir = w_cmd_sel[15] ? DIR_NEG : DIR_POS;
      if (w_mag > c_max_mag) begin
        w_cv_duty = c_max_duty;
        w_cv_sat  = 1'b1;
      end else begin
        w_cv_duty = w_mag[15:0];
      end
    end
  end

  // Only a non-zero to opposite non-zero change is a reversal.
  assign w_reversal = ((r_dir == DIR_POS) && (w_cv_dir == DIR_NEG)) ||
                      ((r_dir == DIR_NEG) && (w_cv_dir == DIR_POS));

  // Next-state and next-output logic
  always_comb begin
    w_state_next = r_state;
    w_duty_next  = r_duty;
    w_dir_next   = r_dir;
    w_sat_next   = r_sat;
    w_cnt_next   = w_boundary ? 16'd0 : (r_cnt + 16'd1);

    if (!i_enable) begin
      w_state_next = ST_IDLE;
      w_duty_next  = 16'd0;
      w_dir_next   = DIR_ZERO;
      w_sat_next   = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_duty_next = 16'd0;
          w_dir_next  = DIR_ZERO;
          w_sat_next  = 1'b0;
          if (w_boundary) begin
            w_state_next = ST_RUN;
            w_duty_next  = w_cv_duty;
            w_dir_next   = w_cv_dir;
            w_sat_next   = w_cv_sat;
          end
        end
        ST_RUN: begin
          if (w_boundary) begin
            if (w_reversal) begin
              w_state_next = ST_REVERSE;
              w_duty_next  = 16'd0;
              w_dir_next   = DIR_ZERO;
              w_sat_next   = 1'b0;
            end else begin
              w_duty_next = w_cv_duty;
              w_dir_next  = w_cv_dir;
              w_sat_next  = w_cv_sat;
            end
          end
        end
        ST_REVERSE: begin
          if (w_boundary) begin
            w_state_next = ST_RUN;
            w_duty_next  = w_cv_duty;
            w_dir_next   = w_cv_dir;
            w_sat_next   = w_cv_sat;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
          w_duty_next  = 16'd0;
          w_dir_next   = DIR_ZERO;
          w_sat_next   = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs. Outputs are computed from the values the
  // counter and duty will hold after this edge so they line up with cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 16'd0;
      r_pending <= 16'd0;
      r_duty    <= 16'd0;
      r_dir     <= DIR_ZERO;
      r_sat     <= 1'b0;
      r_pwm     <= 1'b0;
      r_ain1    <= 1'b0;
      r_ain2    <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_pending <= w_cmd_sel;
      r_duty    <= w_duty_next;
      r_dir     <= w_dir_next;
      r_sat     <= w_sat_next;
      r_pwm     <= (w_cnt_next < w_duty_next);
      r_ain1    <= (w_dir_next == DIR_POS);
      r_ain2    <= (w_dir_next == DIR_NEG);
      r_tick    <= (w_cnt_next == c_last_cnt);
    end
  end

  assign o_pwm_out     = r_pwm;
  assign o_ain1        = r_ain1;
  assign o_ain2        = r_ain2;
  assign o_period_tick = r_tick;
  assign o_saturated   = r_sat;

endmodule
`default_nettype wire
